// File: rtl/dbg_trace_buf_if.sv
// Bundle of decode-record, filter/trigger configuration and drain signals
// for dbg_trace_buf. The slave modport is the trace buffer's view.
interface dbg_trace_buf_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // Decode record
    logic            dec_valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [4:0]      rd;
    logic [4:0]      cause;

    // Filter and trigger configuration
    logic [XLEN-1:0] filt_lo;
    logic [XLEN-1:0] filt_hi;
    logic [XLEN-1:0] trig_pc;
    logic            trig_pc_en;
    logic            trig_cause_en;
    logic            arm;

    // Status
    logic [1:0]      state;
    logic [CW-1:0]   count;
    logic            trig_hit;

    // Drain port
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic [4:0]      out_rd;
    logic [4:0]      out_cause;

    modport master (
        output dec_valid, pc, inst, rd, cause,
        output filt_lo, filt_hi, trig_pc, trig_pc_en, trig_cause_en, arm,
        output out_ready,
        input  state, count, trig_hit,
        input  out_valid, out_pc, out_inst, out_rd, out_cause
    );

    modport slave (
        input  dec_valid, pc, inst, rd, cause,
        input  filt_lo, filt_hi, trig_pc, trig_pc_en, trig_cause_en, arm,
        input  out_ready,
        output state, count, trig_hit,
        output out_valid, out_pc, out_inst, out_rd, out_cause
    );
endinterface

// File: rtl/dbg_trace_buf.sv
// Decode-stage trace capture: circular history of filtered decode records,
// frozen a programmable number of records after a trigger, then drained
// oldest-first over a valid/ready port. Observation only; never stalls decode.
module dbg_trace_buf #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 4
) (
    input logic              clk,
    input logic              rst_n,
    dbg_trace_buf_if.slave   io_bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRecord = 2'd1,
        StPost   = 2'd2,
        StDrain  = 2'd3
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [4:0]      rd;
        logic [4:0]      cause;
    } rec_t;

    state_e        r_state;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW-1:0] r_post_cnt;
    logic          r_trig_hit;
    logic          r_out_valid;
    rec_t          r_out;
    rec_t          r_mem [DEPTH];

    logic          w_accept;
    logic          w_trig;
    logic          w_full;
    logic          w_wr_en;
    logic [AW-1:0] w_rptr_nxt;
    rec_t          w_in;
    rec_t          w_head;

    // Window filter, trigger detection and the entry that becomes the drain head.
    always_comb begin
        w_in       = '{pc: io_bus.pc, inst: io_bus.inst, rd: io_bus.rd, cause: io_bus.cause};
        w_accept   = io_bus.dec_valid && (io_bus.pc >= io_bus.filt_lo)
                     && (io_bus.pc <= io_bus.filt_hi);
        w_trig     = w_accept && ((io_bus.trig_pc_en && (io_bus.pc == io_bus.trig_pc))
                     || (io_bus.trig_cause_en && (io_bus.cause != 5'd0)));
        w_full     = (r_count == CW'(DEPTH));
        w_wr_en    = !io_bus.arm && ((r_state == StRecord) || (r_state == StPost)) && w_accept;
        w_rptr_nxt = w_full ? r_rptr + AW'(1) : r_rptr;
        // An empty buffer's head is the record being written this cycle.
        w_head     = (r_count == '0) ? w_in : r_mem[w_rptr_nxt];
    end

    // Trace storage; contents are only meaningful under count/rptr, so no reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= w_in;
        end
    end

    // Capture/drain FSM with registered status and drain outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_count     <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_post_cnt  <= '0;
            r_trig_hit  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (io_bus.arm) begin
            r_state     <= StRecord;
            r_count     <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_post_cnt  <= '0;
            r_trig_hit  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: ;
                StRecord, StPost: begin
                    if (w_accept) begin
                        r_wptr <= r_wptr + AW'(1);
                        r_rptr <= w_rptr_nxt;
                        if (!w_full) begin
                            r_count <= r_count + CW'(1);
                        end
                        // Entering DRAIN presents the head at once, so out_valid
                        // tracks the state with no bubble.
                        if (r_state == StRecord) begin
                            if (w_trig) begin
                                r_trig_hit <= 1'b1;
                                if (POST_TRIG == 0) begin
                                    r_state     <= StDrain;
                                    r_out_valid <= 1'b1;
                                    r_out       <= w_head;
                                end else begin
                                    r_post_cnt <= AW'(POST_TRIG);
                                    r_state    <= StPost;
                                end
                            end
                        end else begin
                            r_post_cnt <= r_post_cnt - AW'(1);
                            if (r_post_cnt == AW'(1)) begin
                                r_state     <= StDrain;
                                r_out_valid <= 1'b1;
                                r_out       <= w_head;
                            end
                        end
                    end
                end
                StDrain: begin
                    if (r_count == '0) begin
                        r_state     <= StIdle;
                        r_out_valid <= 1'b0;
                    end else if (r_out_valid && io_bus.out_ready) begin
                        r_rptr  <= r_rptr + AW'(1);
                        r_count <= r_count - CW'(1);
                        if (r_count == CW'(1)) begin
                            r_out_valid <= 1'b0;
                            r_state     <= StIdle;
                        end else begin
                            r_out <= r_mem[r_rptr + AW'(1)];
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_bus.state     = r_state;
    assign io_bus.count     = r_count;
    assign io_bus.trig_hit  = r_trig_hit;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_pc    = r_out.pc;
    assign io_bus.out_inst  = r_out.inst;
    assign io_bus.out_rd    = r_out.rd;
    assign io_bus.out_cause = r_out.cause;
endmodule

// File: tb/tb_dbg_trace_buf.sv
// Bench for dbg_trace_buf: a DEPTH=16/POST_TRIG=4 instance (a) and a
// DEPTH=8/POST_TRIG=0 instance (b). Drained records are checked by
// per-instance scoreboard monitors against queues filled at stimulus time.
module tb_dbg_trace_buf;
    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [4:0]  cause;
    } rec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    rec_t q_a[$];
    rec_t q_b[$];

    dbg_trace_buf_if #(.XLEN(64), .DEPTH(16)) a_if ();
    dbg_trace_buf_if #(.XLEN(64), .DEPTH(8))  b_if ();

    dbg_trace_buf #(.XLEN(64), .DEPTH(16), .POST_TRIG(4)) u_dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (a_if)
    );

    dbg_trace_buf #(.XLEN(64), .DEPTH(8), .POST_TRIG(0)) u_dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitors: compare whenever a drain handshake is about to occur.
    always @(negedge clk) begin
        if (rst_n && a_if.out_valid && a_if.out_ready) begin
            if (q_a.size() == 0) begin
                check("drain_a_unexpected", a_if.out_pc, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                rec_t e;
                e = q_a.pop_front();
                check("drain_a_pc", a_if.out_pc, e.pc);
                check("drain_a_inst_rd_cause", {a_if.out_inst, a_if.out_rd, a_if.out_cause},
                      {e.inst, e.rd, e.cause});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_if.out_valid && b_if.out_ready) begin
            if (q_b.size() == 0) begin
                check("drain_b_unexpected", b_if.out_pc, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                rec_t e;
                e = q_b.pop_front();
                check("drain_b_pc", b_if.out_pc, e.pc);
                check("drain_b_inst_rd_cause", {b_if.out_inst, b_if.out_rd, b_if.out_cause},
                      {e.inst, e.rd, e.cause});
            end
        end
    end

    initial begin
        rec_t r;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        a_if.dec_valid = 0; a_if.pc = '0; a_if.inst = '0; a_if.rd = '0; a_if.cause = '0;
        a_if.filt_lo = 64'h0; a_if.filt_hi = 64'hFFFF; a_if.trig_pc = 64'h1000;
        a_if.trig_pc_en = 1; a_if.trig_cause_en = 0; a_if.arm = 0; a_if.out_ready = 0;
        b_if.dec_valid = 0; b_if.pc = '0; b_if.inst = '0; b_if.rd = '0; b_if.cause = '0;
        b_if.filt_lo = 64'h0; b_if.filt_hi = 64'hFFFF; b_if.trig_pc = 64'h0;
        b_if.trig_pc_en = 0; b_if.trig_cause_en = 1; b_if.arm = 0; b_if.out_ready = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_state", 64'(a_if.state), 64'd0);
        check("rst_count", 64'(a_if.count), 64'd0);
        check("rst_trig_hit", 64'(a_if.trig_hit), 64'd0);
        check("rst_out_valid", 64'(a_if.out_valid), 64'd0);
        check("rst_out_pc", a_if.out_pc, 64'd0);

        // Asynchronous reset in the middle of POST
        a_if.arm = 1; tick(); a_if.arm = 0;
        a_if.dec_valid = 1; a_if.pc = 64'h1000; tick(); a_if.dec_valid = 0;
        check("post_state", 64'(a_if.state), 64'd2);
        check("post_trig_hit", 64'(a_if.trig_hit), 64'd1);
        check("post_count", 64'(a_if.count), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_state", 64'(a_if.state), 64'd0);
        check("async_rst_count", 64'(a_if.count), 64'd0);
        check("async_rst_trig_hit", 64'(a_if.trig_hit), 64'd0);
        check("async_rst_out_valid", 64'(a_if.out_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Long run with wrap: trigger at k=64, drain 0x0FD4..0x1010
        a_if.arm = 1; tick(); a_if.arm = 0;
        for (int k = 0; k < 100; k++) begin
            a_if.dec_valid = 1;
            a_if.pc = 64'h0F00 + 64'(4 * k);
            a_if.inst = 32'hC0DE_0000 | 32'(k);
            a_if.rd = 5'(k);
            a_if.cause = 5'd0;
            if (k >= 53 && k <= 68) begin
                r.pc = 64'h0F00 + 64'(4 * k); r.inst = 32'hC0DE_0000 | 32'(k);
                r.rd = 5'(k); r.cause = 5'd0;
                q_a.push_back(r);
            end
            tick();
        end
        a_if.dec_valid = 0;
        check("run_state_drain", 64'(a_if.state), 64'd3);
        check("run_count", 64'(a_if.count), 64'd16);
        check("run_trig_hit", 64'(a_if.trig_hit), 64'd1);
        check("run_out_valid", 64'(a_if.out_valid), 64'd1);
        a_if.out_ready = 1;
        for (int n = 0; n < 100 && a_if.state != 2'd0; n++) tick();
        a_if.out_ready = 0;
        check("run_state_idle", 64'(a_if.state), 64'd0);
        check("run_count_empty", 64'(a_if.count), 64'd0);
        check("run_queue_empty", 64'(q_a.size()), 64'd0);

        // Window filter; out-of-window pc-match does not trigger
        a_if.filt_lo = 64'h2000; a_if.filt_hi = 64'h20FF; a_if.trig_pc = 64'h2100;
        a_if.arm = 1; tick(); a_if.arm = 0;
        a_if.dec_valid = 1;
        a_if.pc = 64'h1FFC; tick();
        a_if.pc = 64'h2000; tick();
        a_if.pc = 64'h20FC; tick();
        a_if.pc = 64'h2100; tick();
        a_if.dec_valid = 0;
        tick();
        check("win_count", 64'(a_if.count), 64'd2);
        check("win_state", 64'(a_if.state), 64'd1);
        check("win_trig_hit", 64'(a_if.trig_hit), 64'd0);

        // Cause trigger with POST_TRIG=0, stall then drain
        b_if.arm = 1; tick(); b_if.arm = 0;
        for (int k = 0; k < 3; k++) begin
            b_if.dec_valid = 1;
            b_if.pc = 64'h100 + 64'(4 * k);
            b_if.inst = 32'hBEEF_0000 | 32'(k);
            b_if.rd = 5'(k + 1);
            b_if.cause = (k == 2) ? 5'd5 : 5'd0;
            r.pc = 64'h100 + 64'(4 * k); r.inst = 32'hBEEF_0000 | 32'(k);
            r.rd = 5'(k + 1); r.cause = (k == 2) ? 5'd5 : 5'd0;
            q_b.push_back(r);
            tick();
        end
        b_if.dec_valid = 0; b_if.cause = 0;
        check("cause_state", 64'(b_if.state), 64'd3);
        check("cause_count", 64'(b_if.count), 64'd3);
        for (int n = 0; n < 5; n++) begin
            check("hold_valid", 64'(b_if.out_valid), 64'd1);
            check("hold_pc", b_if.out_pc, 64'h100);
            tick();
        end
        b_if.out_ready = 1;
        for (int n = 0; n < 50 && b_if.state != 2'd0; n++) tick();
        b_if.out_ready = 0;
        check("cause_state_idle", 64'(b_if.state), 64'd0);
        check("cause_queue_empty", 64'(q_b.size()), 64'd0);

        // Arm has priority in DRAIN; same-cycle record is dropped
        b_if.arm = 1; tick(); b_if.arm = 0;
        for (int k = 0; k < 7; k++) begin
            b_if.dec_valid = 1;
            b_if.pc = 64'h200 + 64'(4 * k);
            b_if.cause = (k == 6) ? 5'd3 : 5'd0;
            tick();
        end
        b_if.dec_valid = 0; b_if.cause = 0;
        check("arm_pre_state", 64'(b_if.state), 64'd3);
        check("arm_pre_count", 64'(b_if.count), 64'd7);
        b_if.arm = 1; b_if.dec_valid = 1; b_if.pc = 64'h300; b_if.cause = 5'd4;
        tick();
        b_if.arm = 0; b_if.dec_valid = 0; b_if.cause = 0;
        check("arm_state", 64'(b_if.state), 64'd1);
        check("arm_count", 64'(b_if.count), 64'd0);
        check("arm_out_valid", 64'(b_if.out_valid), 64'd0);
        check("arm_trig_hit", 64'(b_if.trig_hit), 64'd0);
        tick();
        check("arm_count_hold", 64'(b_if.count), 64'd0);
        b_if.dec_valid = 1; b_if.pc = 64'h400; b_if.inst = 32'h1234_5678;
        b_if.rd = 5'd9; b_if.cause = 5'd7;
        r.pc = 64'h400; r.inst = 32'h1234_5678; r.rd = 5'd9; r.cause = 5'd7;
        q_b.push_back(r);
        tick();
        b_if.dec_valid = 0; b_if.cause = 0;
        check("arm_new_state", 64'(b_if.state), 64'd3);
        check("arm_new_count", 64'(b_if.count), 64'd1);
        b_if.out_ready = 1;
        for (int n = 0; n < 20 && b_if.state != 2'd0; n++) tick();
        b_if.out_ready = 0;
        check("arm_final_idle", 64'(b_if.state), 64'd0);
        check("arm_queue_empty", 64'(q_b.size()), 64'd0);

        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
